// File: rtl/reg_shift_sequencer_pkg.sv
// Shared definitions for the register-specified shift sequencer.
// Contents: shift-type encodings, FSM state encoding and the helper that
// clamps a Rs[7:0] shift amount to the number of single-bit steps needed.
package reg_shift_sequencer_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } seq_state_e;

    // Number of bit positions actually worth shifting. LSL/LSR stop at 33
    // (everything shifted out, including the last carry), ASR stops at 32
    // (fully sign-filled), ROR reduces modulo 32. A ROR by a non-zero
    // multiple of 32 yields 0 here; the caller handles its carry specially.
    function automatic logic [5:0] eff_amount(input logic [1:0] sh_type,
                                              input logic [7:0] amount);
        logic [5:0] eff;
        case (sh_type)
            SH_LSL, SH_LSR: eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
            SH_ASR:         eff = (amount > 8'd32) ? 6'd32 : amount[5:0];
            SH_ROR:         eff = {1'b0, amount[4:0]};
            default:        eff = 6'd0;
        endcase
        return eff;
    endfunction

endpackage

// File: rtl/reg_shift_sequencer_shift_step.sv
// One combinational shifter slice, reused on every SHIFT cycle.
// Ports:
//   value_i  - working value before this step
//   amt_i    - bits to shift this step, 1..STEP (0 passes the value through)
//   type_i   - LSL / LSR / ASR / ROR
//   value_o  - value after this step
//   carry_o  - last bit shifted out in this step
module shift_step
    import reg_shift_sequencer_pkg::*;
(
    input  logic [31:0] value_i,
    input  logic [5:0]  amt_i,
    input  logic [1:0]  type_i,
    output logic [31:0] value_o,
    output logic        carry_o
);

    logic [5:0] lsl_idx_s;
    logic [5:0] rsh_idx_s;
    logic [5:0] wrap_amt_s;

    assign lsl_idx_s  = 6'd32 - amt_i;
    assign rsh_idx_s  = amt_i - 6'd1;
    assign wrap_amt_s = 6'd32 - amt_i;

    // Per-type shift and carry-out selection
    always_comb begin
        value_o = value_i;
        carry_o = 1'b0;
        if (amt_i == 6'd0) begin
            value_o = value_i;
            carry_o = 1'b0;
        end else begin
            case (type_i)
                SH_LSL: begin
                    value_o = value_i << amt_i;
                    carry_o = value_i[lsl_idx_s[4:0]];
                end
                SH_LSR: begin
                    value_o = value_i >> amt_i;
                    carry_o = value_i[rsh_idx_s[4:0]];
                end
                SH_ASR: begin
                    value_o = 32'($signed(value_i) >>> amt_i);
                    carry_o = value_i[rsh_idx_s[4:0]];
                end
                SH_ROR: begin
                    // amt_i == 32 makes the left term a shift by 0, i.e. a full wrap
                    value_o = (value_i >> amt_i) | (value_i << wrap_amt_s);
                    carry_o = value_i[rsh_idx_s[4:0]];
                end
                default: begin
                    value_o = value_i;
                    carry_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_shift_sequencer.sv
// Multi-cycle sequencer for register-specified ARM shifts (amount = Rs[7:0]).
// Accepts one request in IDLE, shifts by up to STEP bits per cycle in SHIFT,
// and presents the result plus shifter carry-out in DONE until taken.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - abandon any in-flight request
//   in_valid/in_ready   - request handshake (in_value, in_amount, in_type, in_carry)
//   out_valid/out_ready - result handshake (out_value, out_carry)
//   stall               - hold the pipeline while busy or while a request waits
module reg_shift_sequencer
    import reg_shift_sequencer_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [7:0]  in_amount,
    input  logic [1:0]  in_type,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_value,
    output logic        out_carry,
    output logic        stall
);

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    seq_state_e  state_q, state_d;
    logic [5:0]  rem_q, rem_d;
    logic [31:0] val_q, val_d;
    logic        carry_q, carry_d;
    logic [1:0]  type_q, type_d;

    logic [5:0]  eff_s;
    logic [5:0]  step_amt_s;
    logic [5:0]  rem_after_s;
    logic [31:0] step_value_s;
    logic        step_carry_s;

    assign eff_s       = eff_amount(in_type, in_amount);
    assign step_amt_s  = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    assign rem_after_s = rem_q - step_amt_s;

    shift_step u_step (
        .value_i (val_q),
        .amt_i   (step_amt_s),
        .type_i  (type_q),
        .value_o (step_value_s),
        .carry_o (step_carry_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        val_d   = val_q;
        carry_d = carry_q;
        type_d  = type_q;
        if (flush) begin
            // Drops any request, including one presented this very cycle
            state_d = ST_IDLE;
            rem_d   = 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        val_d  = in_value;
                        type_d = in_type;
                        rem_d  = eff_s;
                        // Full ROR (non-zero multiple of 32): value kept, carry = bit31
                        if ((in_type == SH_ROR) && (in_amount != 8'd0) && (eff_s == 6'd0)) begin
                            carry_d = in_value[31];
                        end else begin
                            carry_d = in_carry;
                        end
                        state_d = (eff_s != 6'd0) ? ST_SHIFT : ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    val_d   = step_value_s;
                    carry_d = step_carry_s;
                    rem_d   = rem_after_s;
                    state_d = (rem_after_s == 6'd0) ? ST_DONE : ST_SHIFT;
                end
                ST_DONE: begin
                    // No accept here even if in_valid is high: one idle bubble
                    state_d = out_ready ? ST_IDLE : ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = 6'd0;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= 6'd0;
            val_q   <= 32'd0;
            carry_q <= 1'b0;
            type_q  <= SH_LSL;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            carry_q <= carry_d;
            type_q  <= type_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_value = val_q;
    assign out_carry = carry_q;
    assign stall     = (state_q != ST_IDLE) || in_valid;

endmodule

// File: tb/tb_reg_shift_sequencer.sv
module tb_reg_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [7:0]  in_amount;
    logic [1:0]  in_type;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic        out_carry;
    logic        stall;

    int checks;
    int failures;

    reg_shift_sequencer #(.STEP(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_amount (in_amount),
        .in_type   (in_type),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_carry (out_carry),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request at a negedge and count posedges (accept edge = 1)
    // until out_valid is seen. Leaves the result waiting in DONE.
    task automatic issue(input logic [31:0] v, input logic [7:0] a,
                         input logic [1:0] t, input logic c,
                         output int edges, output logic timed_out);
        @(negedge clk);
        in_value  = v;
        in_amount = a;
        in_type   = t;
        in_carry  = c;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        edges     = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            in_valid = 1'b0;
            if (out_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_value !== 32'd0 || out_carry !== 1'b0 || out_valid !== 1'b0 ||
            in_ready !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: value=%h carry=%b ov=%b ir=%b stall=%b, want 0 0 0 1 0",
                     out_value, out_carry, out_valid, in_ready, stall);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_shift(input string name, input logic [31:0] v,
                              input logic [7:0] a, input logic [1:0] t,
                              input logic c, input logic [31:0] exp_v,
                              input logic exp_c, input int exp_edges);
        int   edges;
        logic to;
        issue(v, a, t, c, edges, to);
        checks++;
        if (to || out_value !== exp_v || out_carry !== exp_c) begin
            failures++;
            $display("FAIL %s result: value=%h carry=%b timeout=%b, want %h %b",
                     name, out_value, out_carry, to, exp_v, exp_c);
        end
        checks++;
        if (edges !== exp_edges) begin
            failures++;
            $display("FAIL %s latency: %0d edges, want %0d", name, edges, exp_edges);
        end
        release_result();
    endtask

    task automatic test_stall();
        @(negedge clk);
        in_value = 32'h1; in_amount = 8'd16; in_type = 2'b00; in_carry = 1'b0;
        in_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_idle_req: stall=%b ir=%b, want 1 1", stall, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_shift: stall=%b ir=%b ov=%b, want 1 0 0", stall, in_ready, out_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_value !== 32'h0001_0000) begin
            failures++;
            $display("FAIL stall_result: ov=%b value=%h, want 1 00010000", out_valid, out_value);
        end
        release_result();
    endtask

    task automatic test_back_pressure();
        int   edges;
        logic to;
        logic ok;
        issue(32'h0000_00AB, 8'd4, 2'b01, 1'b0, edges, to);
        ok = !to;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_value !== 32'h0000_000A || out_carry !== 1'b1) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL backpressure_hold: ov=%b ir=%b value=%h carry=%b, want 1 0 0000000a 1",
                     out_valid, in_ready, out_value, out_carry);
        end
        // Release with a new request already waiting: must not be taken in DONE
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_value  = 32'h5; in_amount = 8'd1; in_type = 2'b00;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_value !== 32'h0000_000A || out_carry !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: ov=%b ir=%b value=%h carry=%b, want 0 1 0000000a 1",
                     out_valid, in_ready, out_value, out_carry);
        end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        in_value = 32'hFFFF_0000; in_amount = 8'd24; in_type = 2'b01; in_carry = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);         // accept
        #1;
        in_valid = 1'b0;
        @(posedge clk);         // first SHIFT step
        #1;
        flush = 1'b1;           // during second SHIFT cycle
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle: ir=%b ov=%b, want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL flush_no_result: out_valid seen=%b, want 0", seen);
        end
        // Request presented together with flush is dropped
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; in_amount = 8'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_accept_drop: ir=%b ov=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst_mid_shift();
        @(negedge clk);
        in_value = 32'hFFFF_FFFF; in_amount = 8'd33; in_type = 2'b00; in_carry = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (out_value !== 32'd0 || out_carry !== 1'b0 || out_valid !== 1'b0 ||
            in_ready !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_shift: value=%h carry=%b ov=%b ir=%b stall=%b, want 0 0 0 1 0",
                     out_value, out_carry, out_valid, in_ready, stall);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_value = 32'd0; in_amount = 8'd0; in_type = 2'b00; in_carry = 1'b0;

        test_reset();
        test_shift("lsl_1_by_4",    32'h0000_0001, 8'd4,   2'b00, 1'b0, 32'h0000_0010, 1'b0, 2);
        test_shift("lsr_by_32",     32'h8000_0000, 8'd32,  2'b01, 1'b0, 32'h0000_0000, 1'b1, 5);
        test_shift("lsl_by_40",     32'h0000_0001, 8'd40,  2'b00, 1'b1, 32'h0000_0000, 1'b0, 6);
        test_shift("lsl_by_32",     32'h0000_0001, 8'd32,  2'b00, 1'b0, 32'h0000_0000, 1'b1, 5);
        test_shift("asr_by_40",     32'h8000_0000, 8'd40,  2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1, 5);
        test_shift("asr_by_255",    32'h7FFF_FFFF, 8'd255, 2'b10, 1'b1, 32'h0000_0000, 1'b0, 5);
        test_shift("ror_by_36",     32'h0000_00F0, 8'd36,  2'b11, 1'b1, 32'h0000_000F, 1'b0, 2);
        test_shift("ror_by_32",     32'h8000_0001, 8'd32,  2'b11, 1'b0, 32'h8000_0001, 1'b1, 1);
        test_shift("lsl_by_0",      32'h1234_5678, 8'd0,   2'b00, 1'b1, 32'h1234_5678, 1'b1, 1);
        test_shift("ror_by_12",     32'h0000_0ABC, 8'd12,  2'b11, 1'b0, 32'hABC0_0000, 1'b1, 3);
        test_shift("lsr_by_9",      32'h0000_0300, 8'd9,   2'b01, 1'b0, 32'h0000_0001, 1'b1, 3);
        test_stall();
        test_back_pressure();
        test_flush();
        test_rst_mid_shift();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
